// File: rtl/ram_burst_master.sv
// ram_burst_master
//   Burst initiator for a single-port synchronous RAM. It accepts one burst
//   command at a time over a valid/ready handshake and then performs
//   cmd_len+1 accesses at consecutive addresses. Addresses wrap modulo
//   2^ADDR_W.
//   - Write bursts take their data from a valid/ready stream. A gap in that
//     stream stalls the burst.
//   - Read bursts issue one address per cycle. The data comes back as a
//     valid-only stream, two cycles after each address is issued.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_write, cmd_addr, cmd_len    burst direction, start address, beats-1
//   wr_data_valid/wr_data_ready     write beat handshake
//   wr_data                         write beat payload
//   rd_data_valid, rd_data          read beat stream (no backpressure)
//   busy                            burst in progress, including the read tail
//   ram_address, ram_data_in        RAM address and RAM write data
//   ram_write_enable                RAM write enable
//   ram_data_out                    RAM read data (one cycle after the address)
module ram_burst_master #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int LEN_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_data_valid,
  output logic              wr_data_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_data_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write_enable,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr, cur_addr_nxt;
  logic [LEN_W-1:0]  remaining, remaining_nxt;
  logic              issue;
  logic              issue_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      cur_addr  <= cur_addr_nxt;
      remaining <= remaining_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    cur_addr_nxt     = cur_addr;
    remaining_nxt    = remaining;
    issue            = 1'b0;
    cmd_ready        = 1'b0;
    wr_data_ready    = 1'b0;
    ram_write_enable = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cur_addr_nxt  = cmd_addr;
          remaining_nxt = cmd_len;
          state_nxt     = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        wr_data_ready    = 1'b1;
        // The RAM write is tied straight to the beat handshake. An async
        // reset forces state to IDLE, so the write enable drops at once.
        ram_write_enable = wr_data_valid;
        if (wr_data_valid) begin
          cur_addr_nxt  = cur_addr + 1'b1;
          remaining_nxt = remaining - 1'b1;
          if (remaining == '0) state_nxt = IDLE;
        end
      end
      READ: begin
        issue = 1'b1;
        if (remaining == '0) begin
          state_nxt = DRAIN;
        end else begin
          cur_addr_nxt  = cur_addr + 1'b1;
          remaining_nxt = remaining - 1'b1;
        end
      end
      DRAIN: begin
        // Gives the last issued address time to reach rd_data before IDLE.
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage 1: the address issued last cycle is now registered in the RAM.
  // Stage 2: capture the RAM output and present it as a read beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_q       <= 1'b0;
      rd_data_valid <= 1'b0;
      rd_data       <= '0;
    end else begin
      issue_q       <= issue;
      rd_data_valid <= issue_q;
      if (issue_q) rd_data <= ram_data_out;
    end
  end

  assign ram_address = cur_addr;
  assign ram_data_in = wr_data;
  assign busy        = (state != IDLE) | issue_q;

endmodule

// File: tb/tb_ram_burst_master.sv
module tb_ram_burst_master;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [5:0] cmd_addr;
  logic [2:0] cmd_len;
  logic       wr_data_valid;
  logic       wr_data_ready;
  logic [7:0] wr_data;
  logic       rd_data_valid;
  logic [7:0] rd_data;
  logic       busy;
  logic [5:0] ram_address;
  logic [7:0] ram_data_in;
  logic       ram_write_enable;
  logic [7:0] ram_data_out;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  ram_burst_master #(.DATA_W(8), .ADDR_W(6), .LEN_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready), .wr_data(wr_data),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data), .busy(busy),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_write_enable(ram_write_enable), .ram_data_out(ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: the write commits at the edge; otherwise the addressed word is
  // registered and appears on ram_data_out in the next cycle.
  logic [7:0] mem [0:63];
  logic [7:0] ram_q;
  logic       mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
      ram_q <= 8'h00;
    end else if (ram_write_enable) begin
      mem[ram_address] <= ram_data_in;
    end else begin
      ram_q <= mem[ram_address];
    end
  end
  assign ram_data_out = ram_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every read beat must match the next expected word.
  always @(negedge clk) begin
    if (rd_data_valid) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 32'(rd_data_valid), 32'd0);
      end else begin
        check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [5:0] a, input logic [2:0] l);
    int n;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    n = 0;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    check("cmd_accept_timeout", 32'(n < 100), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wbeat(input logic [7:0] d);
    wr_data_valid = 1'b1;
    wr_data = d;
    @(negedge clk);
    check("wr_ready", 32'(wr_data_ready), 32'd1);
    check("wr_we", 32'(ram_write_enable), 32'd1);
    check("wr_cmd_ready", 32'(cmd_ready), 32'd0);
    check("wr_busy", 32'(busy), 32'd1);
    tick();
    wr_data_valid = 1'b0;
  endtask

  task automatic wgap;
    wr_data_valid = 1'b0;
    @(negedge clk);
    check("gap_we", 32'(ram_write_enable), 32'd0);
    check("gap_busy", 32'(busy), 32'd1);
    tick();
  endtask

  task automatic wr_done;
    @(negedge clk);
    check("wr_end_busy", 32'(busy), 32'd0);
    check("wr_end_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();
  endtask

  // Entered in the first cycle after accept. Read beats are expected in
  // cycles 3..len+3, and busy is expected in cycles 1..len+2.
  task automatic read_window(input int len);
    for (int c = 1; c <= len + 5; c++) begin
      @(negedge clk);
      check("rd_valid_timing", 32'(rd_data_valid), 32'((c >= 3) && (c <= len + 3)));
      check("rd_no_we", 32'(ram_write_enable), 32'd0);
      check("rd_busy", 32'(busy), 32'(c <= len + 2));
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_data_valid = 1'b0; wr_data = '0; mem_clr = 1'b1;
    #3 rst_n = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_wr_ready", 32'(wr_data_ready), 32'd0);
    check("rst_rd_valid", 32'(rd_data_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(ram_address), 32'd0);
    check("rst_din", 32'(ram_data_in), 32'd0);
    check("rst_we", 32'(ram_write_enable), 32'd0);
    rst_n = 1'b1;
    tick();
    mem_clr = 1'b0;

    // Reset in the middle of a write burst, while a beat is offered.
    send_cmd(1'b1, 6'd10, 3'd3);
    wbeat(8'h11);
    wr_data_valid = 1'b1; wr_data = 8'h22;
    #2;
    check("pre_rst_we", 32'(ram_write_enable), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_we", 32'(ram_write_enable), 32'd0);
    check("async_rst_wr_ready", 32'(wr_data_ready), 32'd0);
    tick();
    wr_data_valid = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_rd_valid", 32'(rd_data_valid), 32'd0);
    check("rst_mem10", 32'(mem[10]), 32'h11);
    check("rst_mem11_untouched", 32'(mem[11]), 32'h00);
    tick();

    // Back-to-back write burst.
    send_cmd(1'b1, 6'd4, 3'd3);
    wbeat(8'hA1); wbeat(8'hA2); wbeat(8'hA3); wbeat(8'hA4);
    wr_done();
    check("wb_mem4", 32'(mem[4]), 32'hA1);
    check("wb_mem5", 32'(mem[5]), 32'hA2);
    check("wb_mem6", 32'(mem[6]), 32'hA3);
    check("wb_mem7", 32'(mem[7]), 32'hA4);

    // Read burst of the same region.
    exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
    exp_q.push_back(8'hA3); exp_q.push_back(8'hA4);
    send_cmd(1'b0, 6'd4, 3'd3);
    read_window(3);

    // Clear the region, then repeat the write with a two-cycle gap.
    send_cmd(1'b1, 6'd4, 3'd3);
    wbeat(8'h00); wbeat(8'h00); wbeat(8'h00); wbeat(8'h00);
    wr_done();
    check("clr_mem6", 32'(mem[6]), 32'h00);
    send_cmd(1'b1, 6'd4, 3'd3);
    wbeat(8'hA1); wbeat(8'hA2);
    wgap(); wgap();
    check("gap_mem6_unwritten", 32'(mem[6]), 32'h00);
    wbeat(8'hA3); wbeat(8'hA4);
    wr_done();
    check("sw_mem4", 32'(mem[4]), 32'hA1);
    check("sw_mem5", 32'(mem[5]), 32'hA2);
    check("sw_mem6", 32'(mem[6]), 32'hA3);
    check("sw_mem7", 32'(mem[7]), 32'hA4);

    // Address wrap from 62 through 1.
    send_cmd(1'b1, 6'd62, 3'd3);
    wbeat(8'h01); wbeat(8'h02); wbeat(8'h03); wbeat(8'h04);
    wr_done();
    check("wrap_mem62", 32'(mem[62]), 32'h01);
    check("wrap_mem63", 32'(mem[63]), 32'h02);
    check("wrap_mem0", 32'(mem[0]), 32'h03);
    check("wrap_mem1", 32'(mem[1]), 32'h04);
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    exp_q.push_back(8'h03); exp_q.push_back(8'h04);
    send_cmd(1'b0, 6'd62, 3'd3);
    read_window(3);

    // Single-beat read, with a write command held valid right behind it.
    exp_q.push_back(8'hA2);
    send_cmd(1'b0, 6'd5, 3'd0);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 6'd5; cmd_len = 3'd0;
    @(negedge clk);
    check("b2b_c1_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    @(negedge clk);
    check("b2b_c2_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    @(negedge clk);
    check("b2b_c3_cmd_ready", 32'(cmd_ready), 32'd1);
    check("b2b_c3_rd_valid", 32'(rd_data_valid), 32'd1);
    tick();
    cmd_valid = 1'b0;
    wbeat(8'h5A);
    wr_done();
    check("b2b_mem5", 32'(mem[5]), 32'h5A);

    // Reset during a read burst: the pending beats must never appear.
    send_cmd(1'b0, 6'd4, 3'd3);
    tick();
    #2 rst_n = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("rst_rd_no_valid", 32'(rd_data_valid), 32'd0);
      check("rst_rd_busy", 32'(busy), 32'd0);
      tick();
    end

    tick(); tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_burst_master.md
Name: ram_burst_master

Overview:
- Initiator that drives one single-port synchronous RAM: address, write data, write enable and read data.
- Accepts a burst command over a valid/ready handshake and sequences 1..2^LEN_W consecutive RAM accesses with an auto-incrementing address.
- For writes, it streams write data in from a valid/ready source.
- For reads, it returns RAM data as a valid-only stream.
- Sits between a client (DMA, test sequencer, bus bridge) and the RAM macro.

Parameters:
- DATA_W, 8, RAM data width.
- ADDR_W, 6, RAM address width; addresses wrap modulo 2^ADDR_W.
- LEN_W, 3, burst length field width; beats = cmd_len+1, range 1..8.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when both valid and ready are high.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_W  start address.
- cmd_len  in  LEN_W  beats minus one.
- wr_data_valid  in  1  write beat offered.
- wr_data_ready  out  1  write beat accepted.
- wr_data  in  DATA_W  write beat payload.
- rd_data_valid  out  1  read beat present; single-cycle pulse, no backpressure.
- rd_data  out  DATA_W  read beat payload.
- busy  out  1  high from command accept until the last beat completes.
- ram_address  out  ADDR_W  to RAM address.
- ram_data_in  out  DATA_W  to RAM write data.
- ram_write_enable  out  1  to RAM write enable.
- ram_data_out  in  DATA_W  from RAM read data.

Behaviour:
- RAM contract:
  - Write commits at the clk edge where ram_write_enable=1.
  - With ram_write_enable=0, the RAM registers ram_address at the edge.
  - ram_data_out shows that location from the following cycle on.
- FSM states: IDLE, WRITE, READ, DRAIN. Reset state is IDLE.
- IDLE:
  - cmd_ready=1, ram_write_enable=0.
  - ram_address = cur_addr register, which holds its last value.
  - On accept: cur_addr<=cmd_addr, remaining<=cmd_len, then go to WRITE if cmd_write=1, else READ.
  - Other command fields are ignored when cmd_valid=0.
- WRITE:
  - wr_data_ready=1.
  - Combinational outputs: ram_address=cur_addr, ram_data_in=wr_data, ram_write_enable=wr_data_valid.
  - Each accepted beat writes the RAM on that edge, then cur_addr<=cur_addr+1 (wraps at 2^ADDR_W) and remaining<=remaining-1.
  - Beat on remaining==0 -> IDLE.
  - Gaps (wr_data_valid=0) stall the burst with no RAM write.
- READ:
  - Issues one address per cycle with ram_write_enable=0, ram_address=cur_addr; no stalls.
  - Each issue sets issue_q for one cycle.
  - Issue on remaining==0 -> DRAIN; otherwise increment and decrement as in WRITE.
- Read pipeline:
  - On a cycle with issue_q=1: rd_data<=ram_data_out and rd_data_valid<=1; otherwise rd_data_valid<=0.
  - Latency is 2 cycles from address issue to rd_data_valid.
  - Beats come out in address order, back to back.
- DRAIN: one cycle, ram_write_enable=0, then IDLE.
  - The last rd_data_valid pulse coincides with the first IDLE cycle.
  - A command accepted in that cycle is legal.
- busy = (state!=IDLE) | issue_q.
- cmd_ready=0 in every state except IDLE.
- wr_data_ready=0 outside WRITE.
- Reset values: cmd_ready=1 (IDLE), wr_data_ready=0, rd_data_valid=0, rd_data=0, busy=0, ram_address=0, ram_data_in=0, ram_write_enable=0. All registers reset to 0.
- Reset asserted mid-burst: the burst aborts immediately and ram_write_enable drops asynchronously. Pending read beats are discarded; no rd_data_valid follows.
- Address wrap: start 2^ADDR_W-2, len 3 -> addresses 62,63,0,1 (ADDR_W=6).
- ram_data_in outside WRITE: drive wr_data; the RAM ignores it.

Test Plan:
- Reset: rst_n=0 mid-WRITE with wr_data_valid=1 -> ram_write_enable=0 at once; after release cmd_ready=1, busy=0, rd_data_valid=0.
- Write burst: cmd write addr=4 len=3, data 0xA1,0xA2,0xA3,0xA4 back to back.
  - Expect RAM[4..7] = those values.
  - busy falls on the cycle after the 4th beat.
  - cmd_ready=0 throughout the burst.
- Stalled write: same command with wr_data_valid low for 2 cycles between beats 2 and 3.
  - No write during the gap.
  - Final contents are identical to the back-to-back case.
- Read burst: after the write burst, cmd read addr=4 len=3.
  - rd_data_valid is high for 4 consecutive cycles starting 3 cycles after accept, with rd_data 0xA1..0xA4.
  - ram_write_enable is never 1.
- Wrap: write addr=62 len=3 data 1,2,3,4, then read addr=62 len=3.
  - Expect RAM[62]=1, RAM[63]=2, RAM[0]=3, RAM[1]=4 and reads return 1,2,3,4.
- Back-to-back commands: read len=0 addr=5 with a write command held valid.
  - The write is accepted in the cycle the read beat is valid.
  - The read returns the pre-write value.
  - The write then commits correctly.
